// File: rtl/vga_cfg_arbiter.sv
// vga_cfg_arbiter: round-robin arbiter sharing the VGA configuration bus between N_REQ requesters.
// Define VGA_CFG_BOOT_EN to issue one internal (BOOT_ADDR, BOOT_DATA) transaction after reset.
`timescale 1ns/1ps
module vga_cfg_arbiter #(
   parameter int                      CONFIG_WIDTH = 2,
   parameter int                      N_REQ        = 4,
   parameter int                      ACK_WIN      = 8,
   parameter int                      TIMEOUT      = 1023,
   parameter int                      CNT_WIDTH    = 10,
   parameter logic [CONFIG_WIDTH-1:0] BOOT_ADDR    = 2'b10,
   parameter logic [CONFIG_WIDTH-1:0] BOOT_DATA    = 2'b00
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*CONFIG_WIDTH-1:0] req_addr,
   input  logic [N_REQ*CONFIG_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          c_valid,
   output logic [CONFIG_WIDTH-1:0]       c_addr,
   output logic [CONFIG_WIDTH-1:0]       c_data,
   input  logic                          c_ready,
   output logic                          busy,
   output logic [2:0]                    grant_id,
   output logic                          done,
   output logic                          nack,
   output logic                          timeout
);

   // state      | meaning
   // IDLE       | arbitrate when a request is pending and c_ready = 1
   // ISSUE      | c_valid high for one cycle with the latched addr/data
   // ACK_WAIT   | wait up to ACK_WIN cycles for c_ready to fall
   // BUSY_WAIT  | wait up to TIMEOUT cycles for c_ready to rise
   // DONE       | one-cycle done pulse, nack/timeout valid, record last grant
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_ACK_WAIT  = 3'd2;
   localparam logic [2:0] S_BUSY_WAIT = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

`ifdef VGA_CFG_BOOT_EN
   localparam logic BOOT_INIT = 1'b1;
`else
   localparam logic BOOT_INIT = 1'b0;
`endif

   logic [2:0]              r_state;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [2:0]              r_last_grant;
   logic [2:0]              r_grant_id;
   logic [CONFIG_WIDTH-1:0] r_addr;
   logic [CONFIG_WIDTH-1:0] r_data;
   logic                    r_nack;
   logic                    r_tmo;
   logic                    r_is_boot;
   logic                    r_boot_pend;

   logic                    w_found;
   logic [2:0]              w_win_idx;
   logic [3:0]              w_idx;
   logic [CONFIG_WIDTH-1:0] w_sel_addr;
   logic [CONFIG_WIDTH-1:0] w_sel_data;
   logic                    w_accept;

   // Search upward from last_grant+1, wrapping at N_REQ-1.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = '0;
      w_idx     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = 4'(r_last_grant) + 4'(k);
         if (w_idx >= 4'(N_REQ))
            w_idx = w_idx - 4'(N_REQ);
         for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && (w_idx == 4'(i)) && req_valid[i]) begin
               w_found   = 1'b1;
               w_win_idx = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_win_idx == 3'(i)) begin
            w_sel_addr = req_addr[i*CONFIG_WIDTH +: CONFIG_WIDTH];
            w_sel_data = req_data[i*CONFIG_WIDTH +: CONFIG_WIDTH];
         end
      end
   end

   // Gated by reset so the accept pulse cannot appear while reset is held.
   assign w_accept  = (r_state == S_IDLE) && !r_boot_pend && w_found && c_ready && !rst_n;
   assign req_ready = w_accept ? (N_REQ'(1) << w_win_idx) : '0;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_grant <= 3'(N_REQ-1);
         r_grant_id   <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_nack       <= 1'b0;
         r_tmo        <= 1'b0;
         r_is_boot    <= 1'b0;
         r_boot_pend  <= BOOT_INIT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_boot_pend && c_ready) begin
                  r_boot_pend <= 1'b0;
                  r_is_boot   <= 1'b1;
                  r_grant_id  <= '0;
                  r_addr      <= BOOT_ADDR;
                  r_data      <= BOOT_DATA;
                  r_state     <= S_ISSUE;
               end else if (w_accept) begin
                  r_grant_id <= w_win_idx;
                  r_addr     <= w_sel_addr;
                  r_data     <= w_sel_data;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_nack  <= 1'b0;
               r_tmo   <= 1'b0;
               r_state <= S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
               // A c_ready fall on the limit cycle still counts as an acknowledge.
               if (!c_ready) begin
                  r_cnt   <= '0;
                  r_state <= S_BUSY_WAIT;
               end else if (r_cnt == CNT_WIDTH'(ACK_WIN-1)) begin
                  r_nack  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
               end
            end
            S_BUSY_WAIT: begin
               if (c_ready) begin
                  r_state <= S_DONE;
               end else if (r_cnt == CNT_WIDTH'(TIMEOUT-1)) begin
                  r_tmo   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
               end
            end
            S_DONE: begin
               if (!r_is_boot)
                  r_last_grant <= r_grant_id;
               r_is_boot <= 1'b0;
               r_nack    <= 1'b0;
               r_tmo     <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign c_valid  = (r_state == S_ISSUE);
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign nack     = done & r_nack;
   assign timeout  = done & r_tmo;
   assign c_addr   = busy ? r_addr : '0;
   assign c_data   = busy ? r_data : '0;
   assign grant_id = r_grant_id;

endmodule

// File: tb/tb_vga_cfg_arbiter.sv
// tb_vga_cfg_arbiter: directed vector table, reset/boot sequences and randomized
// transactions against a behavioural arbitration and handshake-timing model.
`timescale 1ns/1ps
module tb_vga_cfg_arbiter;
   localparam int CW = 2;
   localparam int NR = 4;
   localparam int AW = 8;
   localparam int TO = 16;
   localparam int CNTW = 10;

   localparam logic [7:0] A1 = 8'b00_01_11_10;
   localparam logic [7:0] D1 = 8'b10_11_00_01;
   localparam logic [7:0] A2 = 8'b11_10_01_00;
   localparam logic [7:0] D2 = 8'b00_01_10_11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [7:0]    req_addr;
   logic [7:0]    req_data;
   logic [NR-1:0] req_ready;
   logic          c_valid;
   logic [CW-1:0] c_addr;
   logic [CW-1:0] c_data;
   logic          c_ready;
   logic          busy;
   logic [2:0]    grant_id;
   logic          done;
   logic          nack;
   logic          timeout;

   int checks = 0;
   int errors = 0;
   int last_grant = NR - 1;

   always #5 clk = ~clk;

   vga_cfg_arbiter #(
      .CONFIG_WIDTH(CW), .N_REQ(NR), .ACK_WIN(AW), .TIMEOUT(TO), .CNT_WIDTH(CNTW),
      .BOOT_ADDR(2'b10), .BOOT_DATA(2'b00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .c_valid(c_valid), .c_addr(c_addr),
      .c_data(c_data), .c_ready(c_ready), .busy(busy), .grant_id(grant_id),
      .done(done), .nack(nack), .timeout(timeout)
   );

   typedef struct {
      logic [3:0] mask;
      logic [7:0] a;
      logic [7:0] dd;
      int         d;
      int         len;
      int         w;
      logic [1:0] ea;
      logic [1:0] ed;
      int         eoff;
      bit         en;
      bit         et;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Rotating priority list starting just after the last grant.
   function automatic int model_winner(input logic [3:0] mask, input int last);
      int order[$];
      for (int k = 1; k <= NR; k++) order.push_back((last + k) % NR);
      foreach (order[i])
         if (((mask >> order[i]) & 4'b0001) != 4'b0000) return order[i];
      return -1;
   endfunction

   // Cycles from c_valid to done, for a target that holds c_ready high for d
   // acknowledge-window cycles and then low for len cycles.
   function automatic int exp_off(input int d, input int len);
      if (d >= AW) return AW + 1;
      return d + 2 + ((len > TO) ? TO : len);
   endfunction

   task automatic follow(input int d, input int len, input int w, input logic [1:0] ea,
                         input logic [1:0] ed, input int eoff, input bit en, input bit et);
      bit seen;
      seen = 1'b0;
      c_ready = 1'b1;
      for (int j = 1; j <= eoff + 4 && !seen; j++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk("done_latency", 32'(j), 32'(eoff));
            chk("nack", 32'(nack), 32'(en));
            chk("timeout", 32'(timeout), 32'(et));
            chk("done_grant", 32'(grant_id), 32'(w));
            chk("done_bus", 32'({c_valid, c_addr, c_data}), 32'({1'b0, ea, ed}));
         end else begin
            chk("wait_outputs", 32'({c_valid, busy, done, nack, timeout, c_addr, c_data}),
                32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ea, ed}));
         end
         c_ready = seen || ((j - 1) < d) || ((j - 1) >= d + len);
      end
      chk("done_seen", 32'(seen), 32'(1));
      c_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_done", 32'({busy, done, c_valid, c_addr, c_data}), 32'(0));
   endtask

   task automatic run_txn(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] dd,
                          input int d, input int len, input int w, input logic [1:0] ea,
                          input logic [1:0] ed, input int eoff, input bit en, input bit et);
      req_valid = mask;
      req_addr  = a;
      req_data  = dd;
      c_ready   = 1'b1;
      #1;
      chk("accept_pulse", 32'(req_ready), 32'(1) << w);
      @(negedge clk);
      chk("issue", 32'({c_valid, busy, req_ready, c_addr, c_data, grant_id}),
          32'({1'b1, 1'b1, 4'b0000, ea, ed, 3'(w)}));
      req_valid = '0;
      follow(d, len, w, ea, ed, eoff, en, et);
      last_grant = w;
   endtask

`ifdef VGA_CFG_BOOT_EN
   task automatic run_boot();
      bit seen;
      seen = 1'b0;
      req_valid = '0;
      c_ready   = 1'b1;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (c_valid) seen = 1'b1;
      end
      chk("boot_issue_seen", 32'(seen), 32'(1));
      chk("boot_issue", 32'({c_addr, c_data, grant_id, req_ready}),
          32'({2'b10, 2'b00, 3'd0, 4'b0000}));
      follow(0, 2, 0, 2'b10, 2'b00, exp_off(0, 2), 1'b0, 1'b0);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      vecs[0]  = '{4'b0001, A1, D1, 1, 5,  0, 2'b10, 2'b01, 8,  1'b0, 1'b0};
      vecs[1]  = '{4'b1111, A2, D2, 0, 1,  1, 2'b01, 2'b10, 3,  1'b0, 1'b0};
      vecs[2]  = '{4'b1111, A2, D2, 0, 1,  2, 2'b10, 2'b01, 3,  1'b0, 1'b0};
      vecs[3]  = '{4'b1111, A2, D2, 2, 3,  3, 2'b11, 2'b00, 7,  1'b0, 1'b0};
      vecs[4]  = '{4'b1111, A2, D2, 0, 1,  0, 2'b00, 2'b11, 3,  1'b0, 1'b0};
      vecs[5]  = '{4'b0100, A1, D1, 8, 1,  2, 2'b01, 2'b11, 9,  1'b1, 1'b0};
      vecs[6]  = '{4'b0100, A1, D1, 7, 2,  2, 2'b01, 2'b11, 11, 1'b0, 1'b0};
      vecs[7]  = '{4'b1000, A1, D1, 0, 40, 3, 2'b00, 2'b10, 18, 1'b0, 1'b1};
      vecs[8]  = '{4'b0011, A1, D1, 0, 16, 0, 2'b10, 2'b01, 18, 1'b0, 1'b0};
      vecs[9]  = '{4'b1010, A1, D1, 3, 2,  1, 2'b11, 2'b00, 7,  1'b0, 1'b0};
      vecs[10] = '{4'b0101, A2, D2, 1, 20, 2, 2'b10, 2'b01, 19, 1'b0, 1'b1};

      rst_n     = 1'b1;
      req_valid = 4'b0001;
      req_addr  = A1;
      req_data  = D1;
      c_ready   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({req_ready, c_valid, c_addr, c_data, busy, grant_id, done, nack, timeout}),
          32'(0));
      req_valid = '0;
      rst_n     = 1'b0;
`ifdef VGA_CFG_BOOT_EN
      run_boot();
`endif

      for (int i = 0; i < 11; i++)
         run_txn(vecs[i].mask, vecs[i].a, vecs[i].dd, vecs[i].d, vecs[i].len, vecs[i].w,
                 vecs[i].ea, vecs[i].ed, vecs[i].eoff, vecs[i].en, vecs[i].et);

      // Reset while the target is holding c_ready low.
      req_valid = 4'b0010;
      req_addr  = A1;
      req_data  = D1;
      c_ready   = 1'b1;
      w = model_winner(4'b0010, last_grant);
      #1;
      chk("rst_seq_accept", 32'(req_ready), 32'(1) << w);
      @(negedge clk);
      chk("rst_seq_issue", 32'(c_valid), 32'(1));
      req_valid = '0;
      for (int j = 1; j <= 3; j++) begin
         c_ready = 1'b0;
         @(negedge clk);
      end
      chk("rst_seq_busy", 32'({busy, c_valid, done}), 32'({1'b1, 1'b0, 1'b0}));
      req_valid = 4'b1111;
      c_ready   = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("rst_async_outputs",
          32'({req_ready, c_valid, c_addr, c_data, busy, grant_id, done, nack, timeout}), 32'(0));
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("rst_no_done", 32'({done, busy, c_valid}), 32'(0));
      end
      req_valid  = '0;
      rst_n      = 1'b0;
      last_grant = NR - 1;
`ifdef VGA_CFG_BOOT_EN
      run_boot();
`endif
      run_txn(4'b1111, A2, D2, 0, 1, 0, 2'b00, 2'b11, 3, 1'b0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic [3:0] m;
         logic [7:0] a;
         logic [7:0] dd;
         int d;
         int len;
         int wr;
         m   = 4'($urandom_range(1, 15));
         a   = 8'($urandom);
         dd  = 8'($urandom);
         d   = int'($urandom_range(0, AW + 1));
         len = int'($urandom_range(1, TO + 4));
         wr  = model_winner(m, last_grant);
         run_txn(m, a, dd, d, len, wr, a[2*wr +: 2], dd[2*wr +: 2], exp_off(d, len),
                 d >= AW, (d < AW) && (len > TO));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
